// File: rtl/dl_trace_pkg.sv
// Shared types and helpers for the deadlock cycle tracer: FSM states,
// report record layout and a lowest-set-bit priority search.
package dl_trace_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    WALK,
    FINISH
  } state_e;

  // Record layout, LSB first: open, last, proc, comp_id, cycle_id.
  localparam int OPEN_BIT = 0;
  localparam int LAST_BIT = 1;
  localparam int PROC_LSB = 2;

  function automatic int recWidth(input int idxW);
    return 3 * idxW + 4;
  endfunction

  function automatic int compLsb(input int idxW);
    return idxW + 2;
  endfunction

  function automatic int cycleLsb(input int idxW);
    return 2 * idxW + 3;
  endfunction

  // Returns 64 when no bit is set.
  function automatic int lowestSet(input logic [63:0] v);
    int idx;
    idx = 64;
    for (int i = 63; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/dl_rpt_fifo.sv
// First-word fall-through report FIFO; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module dl_rpt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q, rdPtr_q;
  logic             doPush, doPop;

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign doPop   = pop_i & ~empty_o;
  assign doPush  = push_i & (~full_o | doPop);
  assign rdata_o = mem_q[rdPtr_q[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
        wrPtr_q                <= wrPtr_q + 1'b1;
      end
      if (doPop) rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

endmodule

// File: rtl/dl_cycle_tracer.sv
// Hardware deadlock tracer: snapshots stuck processes, walks the wait-for
// graph and streams one report record per dependence-cycle member.
module dl_cycle_tracer
  import dl_trace_pkg::*;
#(
  parameter int PROC_NUM = 4,
  parameter int IDX_W    = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1,
  parameter int CNT_W    = 16,
  parameter int DEPTH    = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CNT_W-1:0]          thresh,
  input  logic [PROC_NUM-1:0]       blk_vec,
  input  logic [PROC_NUM*IDX_W-1:0] wait_idx,
  output logic                      dl_detect_out,
  output logic                      token_clear,
  output logic                      done,
  output logic                      rpt_valid,
  input  logic                      rpt_ready,
  output logic [3*IDX_W+3:0]        rpt_data
);
  localparam int RW        = recWidth(IDX_W);
  localparam int ID_W      = IDX_W + 1;
  localparam int COMP_LSB  = compLsb(IDX_W);
  localparam int CYCLE_LSB = cycleLsb(IDX_W);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q [PROC_NUM];
  logic [CNT_W-1:0]    thrEff;
  logic [PROC_NUM-1:0] stuck, stuckVec_q, stuckVec_d, doneVec_q, doneVec_d, visited;
  logic [IDX_W-1:0]    cur_q, cur_d, origin_q, origin_d, nxt;
  logic [ID_W-1:0]     cycleId_q, cycleId_d, compId_q, compId_d;
  logic                det_q, det_d, fin_q, fin_d;
  logic                push, pop, full, empty, canPush, last, openFlag, tokenPulse;
  logic                nxtInRange, nxtStuck, nxtVisited, closing, openEnd, noOrigin;
  logic [RW-1:0]       pushData;
  int                  originIdx;

  assign thrEff = (thresh == '0) ? CNT_W'(1) : thresh;

  always_comb begin
    stuck = '0;
    for (int i = 0; i < PROC_NUM; i++) stuck[i] = (cnt_q[i] >= thrEff);
  end

  // Counters only run while idle; afterwards the captured snapshot is traced.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PROC_NUM; i++) cnt_q[i] <= '0;
    end else if (state_q == IDLE) begin
      for (int i = 0; i < PROC_NUM; i++) begin
        if (!blk_vec[i])        cnt_q[i] <= '0;
        else if (cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign originIdx  = lowestSet(64'(stuckVec_q & ~doneVec_q));
  assign noOrigin   = (originIdx >= PROC_NUM);
  assign nxt        = wait_idx[int'(cur_q)*IDX_W +: IDX_W];
  assign nxtInRange = (int'(nxt) < PROC_NUM);
  assign visited    = doneVec_q | (PROC_NUM'(1) << cur_q);
  assign nxtStuck   = nxtInRange && stuckVec_q[nxt];
  assign nxtVisited = nxtInRange && visited[nxt];
  assign closing    = (nxt == origin_q);
  assign openEnd    = !nxtStuck || nxtVisited || (compId_q == ID_W'(PROC_NUM));
  assign pop        = rpt_valid & rpt_ready;
  assign canPush    = ~full | pop;

  always_comb begin
    state_d    = state_q;
    stuckVec_d = stuckVec_q;
    doneVec_d  = doneVec_q;
    cur_d      = cur_q;
    origin_d   = origin_q;
    cycleId_d  = cycleId_q;
    compId_d   = compId_q;
    det_d      = det_q;
    fin_d      = fin_q;
    push       = 1'b0;
    last       = 1'b0;
    openFlag   = 1'b0;
    tokenPulse = 1'b0;
    case (state_q)
      IDLE: begin
        if (|stuck) begin
          stuckVec_d = stuck;
          det_d      = 1'b1;
          cycleId_d  = ID_W'(1);
          state_d    = SELECT;
        end
      end
      SELECT: begin
        if (noOrigin) begin
          state_d = FINISH;
        end else begin
          cur_d    = IDX_W'(originIdx);
          origin_d = IDX_W'(originIdx);
          compId_d = ID_W'(1);
          state_d  = WALK;
        end
      end
      WALK: begin
        if (canPush) begin
          push             = 1'b1;
          doneVec_d[cur_q] = 1'b1;
          if (closing) begin
            last       = 1'b1;
            tokenPulse = 1'b1;
            cycleId_d  = cycleId_q + ID_W'(1);
            state_d    = SELECT;
          end else if (openEnd) begin
            last      = 1'b1;
            openFlag  = 1'b1;
            cycleId_d = cycleId_q + ID_W'(1);
            state_d   = SELECT;
          end else begin
            cur_d    = nxt;
            compId_d = compId_q + ID_W'(1);
          end
        end
      end
      FINISH: fin_d = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      stuckVec_q <= '0;
      doneVec_q  <= '0;
      cur_q      <= '0;
      origin_q   <= '0;
      cycleId_q  <= '0;
      compId_q   <= '0;
      det_q      <= 1'b0;
      fin_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      stuckVec_q <= stuckVec_d;
      doneVec_q  <= doneVec_d;
      cur_q      <= cur_d;
      origin_q   <= origin_d;
      cycleId_q  <= cycleId_d;
      compId_q   <= compId_d;
      det_q      <= det_d;
      fin_q      <= fin_d;
    end
  end

  always_comb begin
    pushData                            = '0;
    pushData[OPEN_BIT]                  = openFlag;
    pushData[LAST_BIT]                  = last;
    pushData[PROC_LSB +: IDX_W]         = cur_q;
    pushData[COMP_LSB +: ID_W]          = compId_q;
    pushData[CYCLE_LSB +: ID_W]         = cycleId_q;
  end

  dl_rpt_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (pushData),
    .pop_i   (pop),
    .rdata_o (rpt_data),
    .full_o  (full),
    .empty_o (empty)
  );

  assign rpt_valid     = ~empty;
  assign dl_detect_out = det_q;
  assign done          = fin_q;
  assign token_clear   = tokenPulse;

endmodule
